spi_raspberry_slave: RTL and testbench
======================================

Name: spi_raspberry_slave

Overview:
- SPI mode-0 slave between the Raspberry Pi host SPI bus and FPGA internal logic; oversamples the asynchronous SPI pins with the system clock.
- Full-duplex frames of up to 512 bits, LSB-first.
- Captures host data into a 512-bit receive word and shifts out a 512-bit transmit word.
- Decodes the first received byte as a command and pulses read/write strobes at frame end.

Parameters:
- SPI_FILTER, 2, number of consecutive identical clk samples needed before a synchronized SPI input (cs, sclk, mosi) is accepted; legal range 1..8.

Ports:
- clk  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- spi_cs  in  1  SPI chip select, active low, asynchronous
- spi_clk  in  1  SPI clock, idle low, asynchronous
- spi_mosi  in  1  host-to-slave data
- data_tx  in  512  word to transmit; sampled at frame start
- spi_miso_tri  out  1  MISO tristate control; 1 = high-Z, 0 = drive
- spi_miso  out  1  slave-to-host data
- data_rx  out  512  last valid received frame
- spi_read  out  1  one-clk pulse: valid read command received
- spi_write  out  1  one-clk pulse: valid write command received

Behaviour:
- Input conditioning:
  - Each SPI input passes through a 2-FF synchronizer, then a filter.
  - The filter output changes only after SPI_FILTER consecutive equal samples.
  - All edge detection uses filtered signals.
  - Input-to-edge latency is 2+SPI_FILTER clk.
  - Requirement: every SPI clock half-period is at least 2*(SPI_FILTER+3) clk.
- Frame start (filtered cs falling edge):
  - Load data_tx into the tx shift register.
  - Clear the bit counter and the rx shift register.
  - spi_miso_tri=0; spi_miso=data_tx[0] on the next clk.
- Rising sclk edge while selected:
  - rx_shift[bitcnt] <= filtered mosi.
  - bitcnt increments; it saturates at 512, and bits beyond 512 are ignored.
- Falling sclk edge while selected:
  - spi_miso <= tx bit at index bitcnt.
  - Outputs 0 once bitcnt >= 512.
- Frame end (filtered cs rising edge), if bitcnt >= 8:
  - data_rx <= rx_shift, with unreceived bits 0.
  - Command byte = rx_shift[7:0]: bit0 ENABLE, bit1 READ, bit2 WRITE, bits[7:3] reserved and ignored.
  - spi_read pulses 1 clk when ENABLE&READ; spi_write pulses 1 clk when ENABLE&WRITE.
  - Both strobes may pulse in the same clk.
- Frame end with bitcnt < 8: frame discarded; data_rx unchanged; no strobes.
- spi_miso_tri=1 and spi_miso=0 whenever not selected.
- data_rx is held constant between frame ends.
- Reset (any time, including mid-frame):
  - data_rx=0, spi_read=0, spi_write=0, spi_miso=0, spi_miso_tri=1.
  - Bit counter and shift registers cleared; filters preset to idle (cs=1, sclk=0, mosi=0).
  - An aborted frame yields no strobes.
  - If cs is still low after reset releases, no frame is started until a fresh cs falling edge.
- sclk edges while cs is high are ignored.

Optional Feature:
- SPI_MSB_FIRST_EN defined:
  - Bit order is reversed: first received bit goes to data_rx[511].
  - First transmitted bit is data_tx[511].
  - Command byte is data_rx[511:504], with ENABLE = data_rx[511], READ = [510], WRITE = [509].
- Undefined: LSB-first as described above.

Decomposition:
- Shared package spi_raspberry_pkg holds:
  - FRAME_BITS=512 and BITCNT_W=10.
  - Command bit indices CMD_ENABLE=0, CMD_READ=1, CMD_WRITE=2.
  - Reset/idle values for the filters.
- One natural sub-module, spi_input_filter (2-FF synchronizer + SPI_FILTER-deep glitch filter, 1-bit), instantiated three times.

Test Plan:
- Write command: reset, data_tx=0x1234; cs low, 16 bits LSB-first with byte0=0x05, byte1=0x00; cs high -> spi_write one 1-clk pulse, spi_read stays 0, data_rx=0x0005.
- MISO: same frame -> spi_miso_tri=0 while selected; first 8 sampled MISO bits = 0,0,1,0,1,1,0,0 (0x34 LSB-first); next byte gives 0x12; tri=1 after cs high.
- Read+write: byte0=0x07 -> spi_read and spi_write pulse in the same clk; byte0=0x06 (ENABLE=0) -> no strobes, data_rx=0x0006.
- Short frame: 5 bits then cs high -> data_rx unchanged, no strobes; separately, 520 bits -> only first 512 stored, bitcnt saturates.
- Glitch: 1-clk pulse on spi_clk with SPI_FILTER=2 -> no bit captured, bitcnt unchanged.
- Reset mid-frame after 10 bits -> all outputs at reset values; following cs rise produces no strobe and data_rx=0.

Source files
------------

// File: rtl/spi_raspberry_pkg.sv
// Shared constants, frame state encoding and bit-order helper for the Raspberry Pi SPI slave.
// Define SPI_MSB_FIRST_EN to switch frame bit order to MSB-first.
package spi_raspberry_pkg;

    localparam int FRAME_BITS = 512;
    localparam int BITCNT_W   = 10;

    localparam logic [8:0] CMD_ENABLE = 9'd0;
    localparam logic [8:0] CMD_READ   = 9'd1;
    localparam logic [8:0] CMD_WRITE  = 9'd2;

    localparam logic CS_IDLE   = 1'b1;
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic MOSI_IDLE = 1'b0;

    typedef enum logic [1:0] {
        ST_ARM,
        ST_IDLE,
        ST_ACTIVE
    } frame_state_t;

    // Maps the n-th bit on the wire to its position in the 512-bit words.
    function automatic logic [8:0] frame_index(input logic [8:0] n);
`ifdef SPI_MSB_FIRST_EN
        return ~n;
`else
        return n;
`endif
    endfunction

endpackage

// File: rtl/spi_input_filter.sv
// Two-flop synchronizer followed by a glitch filter: the output only follows the
// input after SPI_FILTER consecutive clk samples that disagree with it.
module spi_input_filter #(
    parameter int   SPI_FILTER = 2,
    parameter logic IDLE_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic filtered
);

    logic [1:0] sync;
    logic [3:0] run_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync     <= {2{IDLE_VAL}};
            filtered <= IDLE_VAL;
            run_cnt  <= '0;
        end else begin
            sync <= {sync[0], pin};
            if (sync[1] == filtered) begin
                run_cnt <= '0;
            end else if (run_cnt == 4'(SPI_FILTER - 1)) begin
                filtered <= sync[1];
                run_cnt  <= '0;
            end else begin
                run_cnt <= run_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/spi_raspberry_slave.sv
// SPI mode-0 slave for the Raspberry Pi host: 512-bit full-duplex frames with a
// command byte that raises read/write strobes at frame end. Macro: SPI_MSB_FIRST_EN.
module spi_raspberry_slave
    import spi_raspberry_pkg::*;
#(
    parameter int SPI_FILTER = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_cs,
    input  logic                  spi_clk,
    input  logic                  spi_mosi,
    input  logic [FRAME_BITS-1:0] data_tx,
    output logic                  spi_miso_tri,
    output logic                  spi_miso,
    output logic [FRAME_BITS-1:0] data_rx,
    output logic                  spi_read,
    output logic                  spi_write
);

    logic cs_f, sclk_f, mosi_f;
    logic cs_q, sclk_q;
    logic cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic frame_start, frame_end, arm_done;
    logic [3:0] arm_cnt;
    logic [BITCNT_W-1:0] bitcnt;
    logic [FRAME_BITS-1:0] tx_word, rx_shift;
    frame_state_t state, state_next;

    spi_input_filter #(.SPI_FILTER(SPI_FILTER), .IDLE_VAL(CS_IDLE)) u_cs_filter (
        .clk(clk), .reset(reset), .pin(spi_cs), .filtered(cs_f)
    );
    spi_input_filter #(.SPI_FILTER(SPI_FILTER), .IDLE_VAL(SCLK_IDLE)) u_sclk_filter (
        .clk(clk), .reset(reset), .pin(spi_clk), .filtered(sclk_f)
    );
    spi_input_filter #(.SPI_FILTER(SPI_FILTER), .IDLE_VAL(MOSI_IDLE)) u_mosi_filter (
        .clk(clk), .reset(reset), .pin(spi_mosi), .filtered(mosi_f)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_q   <= CS_IDLE;
            sclk_q <= SCLK_IDLE;
        end else begin
            cs_q   <= cs_f;
            sclk_q <= sclk_f;
        end
    end

    assign cs_fall   = cs_q & ~cs_f;
    assign cs_rise   = ~cs_q & cs_f;
    assign sclk_rise = ~sclk_q & sclk_f;
    assign sclk_fall = sclk_q & ~sclk_f;

    // After reset the filters are preset to idle, so a cs already held low would
    // look like a fresh falling edge once the pipeline flushes; ST_ARM waits out
    // that flush and then insists on seeing cs high before a frame may start.
    assign arm_done = (arm_cnt == 4'(SPI_FILTER + 3));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_ARM;
            arm_cnt <= '0;
        end else begin
            state <= state_next;
            if (!arm_done) begin
                arm_cnt <= arm_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            ST_ARM: begin
                if (arm_done && cs_f) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    frame_start = 1'b1;
                    state_next  = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    frame_end  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_ARM;
        endcase
    end

    // A bit counter value of 512 marks a full frame; further sclk edges are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_word      <= '0;
            rx_shift     <= '0;
            bitcnt       <= '0;
            data_rx      <= '0;
            spi_read     <= 1'b0;
            spi_write    <= 1'b0;
            spi_miso     <= 1'b0;
            spi_miso_tri <= 1'b1;
        end else begin
            spi_read  <= 1'b0;
            spi_write <= 1'b0;
            if (frame_start) begin
                tx_word      <= data_tx;
                rx_shift     <= '0;
                bitcnt       <= '0;
                spi_miso_tri <= 1'b0;
                spi_miso     <= data_tx[frame_index(9'd0)];
            end else if (frame_end) begin
                spi_miso_tri <= 1'b1;
                spi_miso     <= 1'b0;
                if (bitcnt >= BITCNT_W'(8)) begin
                    data_rx   <= rx_shift;
                    spi_read  <= rx_shift[frame_index(CMD_ENABLE)] & rx_shift[frame_index(CMD_READ)];
                    spi_write <= rx_shift[frame_index(CMD_ENABLE)] & rx_shift[frame_index(CMD_WRITE)];
                end
            end else if (state == ST_ACTIVE) begin
                if (sclk_rise && !bitcnt[9]) begin
                    rx_shift[frame_index(bitcnt[8:0])] <= mosi_f;
                    bitcnt <= bitcnt + BITCNT_W'(1);
                end
                if (sclk_fall) begin
                    spi_miso <= bitcnt[9] ? 1'b0 : tx_word[frame_index(bitcnt[8:0])];
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_raspberry_slave.sv
// Scoreboard bench for spi_raspberry_slave: stimulus queues expected frame-end results
// and MISO bits; monitors pop and compare when the DUT presents them.
module tb_spi_raspberry_slave;

    localparam int HALF = 12;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [511:0] rx;
    } frame_exp_t;

    logic         clk;
    logic         reset;
    logic         spi_cs;
    logic         spi_clk;
    logic         spi_mosi;
    logic [511:0] data_tx;
    logic         spi_miso_tri;
    logic         spi_miso;
    logic [511:0] data_rx;
    logic         spi_read;
    logic         spi_write;

    int            n_checks;
    int            n_fail;
    frame_exp_t    strobe_q[$];
    logic          miso_q[$];
    logic [1023:0] miso_seen;
    int            miso_idx;
    bit            glitching;
    logic [511:0]  last_rx;
    bit            pulse_chk;

    spi_raspberry_slave #(.SPI_FILTER(2)) dut (
        .clk(clk),
        .reset(reset),
        .spi_cs(spi_cs),
        .spi_clk(spi_clk),
        .spi_mosi(spi_mosi),
        .data_tx(data_tx),
        .spi_miso_tri(spi_miso_tri),
        .spi_miso(spi_miso),
        .data_rx(data_rx),
        .spi_read(spi_read),
        .spi_write(spi_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-end monitor: any strobe or data_rx change must match the next queued frame.
    always @(negedge clk) begin
        frame_exp_t e;
        if (reset) begin
            last_rx   = data_rx;
            pulse_chk = 1'b0;
        end else begin
            if (pulse_chk) begin
                n_checks++;
                if (spi_read || spi_write) begin
                    n_fail++;
                    $display("[TB] FAIL strobe_width: read=%0b write=%0b, required 0 one clk after pulse",
                             spi_read, spi_write);
                end
                pulse_chk = 1'b0;
            end
            if (spi_read || spi_write || data_rx !== last_rx) begin
                n_checks++;
                if (strobe_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_frame_end: read=%0b write=%0b data_rx=%h",
                             spi_read, spi_write, data_rx);
                end else begin
                    e = strobe_q.pop_front();
                    if (spi_read !== e.rd || spi_write !== e.wr || data_rx !== e.rx) begin
                        n_fail++;
                        $display("[TB] FAIL frame_end: got rd=%0b wr=%0b rx=%h, required rd=%0b wr=%0b rx=%h",
                                 spi_read, spi_write, data_rx, e.rd, e.wr, e.rx);
                    end
                end
                pulse_chk = spi_read | spi_write;
                last_rx   = data_rx;
            end
        end
    end

    // MISO monitor: the host samples MISO on every rising sclk while selected.
    always @(posedge spi_clk) begin
        logic e;
        if (!glitching && !spi_cs) begin
            n_checks++;
            if (miso_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL miso_underflow: sampled miso=%0b with nothing expected", spi_miso);
            end else begin
                e = miso_q.pop_front();
                if (spi_miso !== e || spi_miso_tri !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL miso_bit%0d: got miso=%0b tri=%0b, required miso=%0b tri=0",
                             miso_idx, spi_miso, spi_miso_tri, e);
                end
            end
            miso_seen[miso_idx] = spi_miso;
            miso_idx++;
        end
    end

    task automatic check_output(input string name, input logic [511:0] actual,
                                input logic [511:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_tri"}, 512'(spi_miso_tri), 512'd1);
        check_output({tag, "_miso"}, 512'(spi_miso), 512'd0);
        check_output({tag, "_rx"}, data_rx, 512'd0);
        check_output({tag, "_read"}, 512'(spi_read), 512'd0);
        check_output({tag, "_write"}, 512'(spi_write), 512'd0);
    endtask

    // Drives one host frame; glitch_at inserts a 1-clk sclk pulse after that bit.
    task automatic apply_stimulus(input int nbits, input logic [1023:0] bits,
                                  input logic [511:0] tx, input int glitch_at,
                                  input bit end_frame);
        data_tx  = tx;
        miso_idx = 0;
        @(negedge clk);
        spi_cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = bits[i];
            miso_q.push_back((i < 512) ? tx[i] : 1'b0);
            repeat (HALF) @(negedge clk);
            spi_clk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_clk = 1'b0;
            if (i == glitch_at) begin
                repeat (4) @(negedge clk);
                spi_mosi  = ~spi_mosi;
                glitching = 1'b1;
                spi_clk   = 1'b1;
                @(negedge clk);
                spi_clk   = 1'b0;
                glitching = 1'b0;
                repeat (8) @(negedge clk);
            end
        end
        if (end_frame) begin
            repeat (HALF) @(negedge clk);
            spi_cs = 1'b1;
            repeat (3 * HALF) @(negedge clk);
        end
    endtask

    initial begin
        logic [511:0] big_rx;
        n_checks  = 0;
        n_fail    = 0;
        glitching = 1'b0;
        miso_idx  = 0;
        miso_seen = '0;
        last_rx   = '0;
        pulse_chk = 1'b0;
        reset     = 1'b1;
        spi_cs    = 1'b1;
        spi_clk   = 1'b0;
        spi_mosi  = 1'b0;
        data_tx   = '0;
        repeat (5) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Write command 0x05, transmit word 0x1234.
        strobe_q.push_back('{rd: 1'b0, wr: 1'b1, rx: 512'h0005});
        apply_stimulus(16, 1024'h0005, 512'h1234, -1, 1'b1);
        check_output("miso_byte0", 512'(miso_seen[7:0]), 512'h34);
        check_output("miso_byte1", 512'(miso_seen[15:8]), 512'h12);
        check_output("tri_after_frame", 512'(spi_miso_tri), 512'd1);
        check_output("miso_after_frame", 512'(spi_miso), 512'd0);

        // Read+write together, then ENABLE clear.
        strobe_q.push_back('{rd: 1'b1, wr: 1'b1, rx: 512'h0007});
        apply_stimulus(16, 1024'h0007, 512'hA5C3, -1, 1'b1);
        strobe_q.push_back('{rd: 1'b0, wr: 1'b0, rx: 512'h0006});
        apply_stimulus(16, 1024'h0006, 512'h0F0F, -1, 1'b1);

        // Short frame is discarded.
        apply_stimulus(5, 1024'h15, 512'h1, -1, 1'b1);
        check_output("short_frame_rx", data_rx, 512'h0006);

        // Oversize frame: 520 bits, only the first 512 stored, MISO 0 past the end.
        big_rx = {{63{8'h5A}}, 8'h03};
        strobe_q.push_back('{rd: 1'b1, wr: 1'b0, rx: big_rx});
        apply_stimulus(520, {504'd0, 8'hFF, {63{8'h5A}}, 8'h03}, {512{1'b1}}, -1, 1'b1);

        // A 1-clk sclk glitch after bit 3 must not capture a bit.
        strobe_q.push_back('{rd: 1'b0, wr: 1'b1, rx: 512'hA505});
        apply_stimulus(16, 1024'hA505, 512'h0, 3, 1'b1);
        check_output("glitch_rx", data_rx, 512'hA505);

        // Reset after 10 bits of a read+write frame.
        apply_stimulus(10, 1024'h0007, 512'h3, -1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("midreset");
        reset = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_cs = 1'b1;
        repeat (3 * HALF) @(negedge clk);
        check_output("post_reset_rx", data_rx, 512'd0);
        check_output("post_reset_tri", 512'(spi_miso_tri), 512'd1);

        // A fresh frame after reset must work normally.
        strobe_q.push_back('{rd: 1'b0, wr: 1'b1, rx: 512'h0005});
        apply_stimulus(16, 1024'h0005, 512'h1234, -1, 1'b1);
        check_output("recover_miso_byte0", 512'(miso_seen[7:0]), 512'h34);

        check_output("strobe_queue_empty", 512'(strobe_q.size()), 512'd0);
        check_output("miso_queue_empty", 512'(miso_q.size()), 512'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
